// File: rtl/dhash_pkg.sv
// ---------------------------------------------------------------------------
// dhash_pkg
// Shared constants and FSM encoding for the dhash sequencing controller.
//   ROW_LIM      pixels per row handed to the dhash core
//   COL_LIM      rows per frame
//   COUNT_WIDTH  row index width (col index is one bit narrower)
//   PIX_WIDTH    pixel width
//   OUT_WIDTH    hash width
//   TIMEOUT      cycles the controller waits for the core result
// ---------------------------------------------------------------------------
package dhash_pkg;

    localparam int ROW_LIM     = 9;
    localparam int COL_LIM     = 8;
    localparam int COUNT_WIDTH = 4;
    localparam int PIX_WIDTH   = 8;
    localparam int OUT_WIDTH   = (ROW_LIM - 1) * COL_LIM;
    localparam int TIMEOUT     = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FEED = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/dhash_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// dhash_seq_ctrl_if
// Bundles the three buses around the sequencing controller:
//   pixel stream : s_pix, s_valid (in)  / s_ready (out)
//   core drive   : core_pix, core_row, core_col (out)
//   core result  : core_vld, core_hash (in)
//   result       : m_hash, m_valid (out) / m_ready (in)
// Modport slave is the controller's view, master the surrounding system's.
// ---------------------------------------------------------------------------
interface dhash_seq_ctrl_if #(
    parameter int PIX_WIDTH   = dhash_pkg::PIX_WIDTH,
    parameter int COUNT_WIDTH = dhash_pkg::COUNT_WIDTH,
    parameter int OUT_WIDTH   = dhash_pkg::OUT_WIDTH
);

    logic [PIX_WIDTH-1:0]   s_pix;
    logic                   s_valid;
    logic                   s_ready;

    logic [PIX_WIDTH-1:0]   core_pix;
    logic [COUNT_WIDTH-1:0] core_row;
    logic [COUNT_WIDTH-2:0] core_col;

    logic                   core_vld;
    logic [OUT_WIDTH-1:0]   core_hash;

    logic [OUT_WIDTH-1:0]   m_hash;
    logic                   m_valid;
    logic                   m_ready;

    modport slave (
        input  s_pix, s_valid, core_vld, core_hash, m_ready,
        output s_ready, core_pix, core_row, core_col, m_hash, m_valid
    );

    modport master (
        output s_pix, s_valid, core_vld, core_hash, m_ready,
        input  s_ready, core_pix, core_row, core_col, m_hash, m_valid
    );

endinterface

// File: rtl/dhash_idx_cnt.sv
// ---------------------------------------------------------------------------
// dhash_idx_cnt
// Row/col index generator. Row is the fast counter; col advances when row
// wraps. Both wrap together after the last pixel of the frame.
//   clk, rst     clock, async active-low reset
//   en_i         advance by one pixel
//   clr_i        synchronous clear (wins over en_i)
//   row_o/col_o  current indices
//   row_wrap_o   row is at ROW_LIM-1
//   col_wrap_o   col is at COL_LIM-1
// ---------------------------------------------------------------------------
module dhash_idx_cnt #(
    parameter int ROW_LIM     = dhash_pkg::ROW_LIM,
    parameter int COL_LIM     = dhash_pkg::COL_LIM,
    parameter int COUNT_WIDTH = dhash_pkg::COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   clr_i,
    output logic [COUNT_WIDTH-1:0] row_o,
    output logic [COUNT_WIDTH-2:0] col_o,
    output logic                   row_wrap_o,
    output logic                   col_wrap_o
);

    localparam int CW = COUNT_WIDTH - 1;
    localparam logic [COUNT_WIDTH-1:0] ROW_MAX = COUNT_WIDTH'(ROW_LIM - 1);
    localparam logic [CW-1:0]          COL_MAX = CW'(COL_LIM - 1);

    logic [COUNT_WIDTH-1:0] row_q, row_d;
    logic [CW-1:0]          col_q, col_d;

    assign row_wrap_o = (row_q == ROW_MAX);
    assign col_wrap_o = (col_q == COL_MAX);
    assign row_o      = row_q;
    assign col_o      = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            if (row_wrap_o) begin
                row_d = '0;
                col_d = col_wrap_o ? '0 : col_q + 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/dhash_seq_ctrl.sv
// ---------------------------------------------------------------------------
// dhash_seq_ctrl
// Sequences one frame of pixels into a dhash core and returns its hash.
//   clk, rst  clock, async active-low reset
//   start     one-cycle request to hash a frame (honoured only in IDLE)
//   bus       pixel stream in, core drive out, core result in, hash out
//   busy      high whenever the controller is not idle
//   err       one-cycle pulse when the core never reports a result
// Flow: IDLE -> FEED (ROW_LIM*COL_LIM beats) -> WAIT (core result or
// timeout) -> HOLD (until the result is accepted) -> IDLE.
// ---------------------------------------------------------------------------
module dhash_seq_ctrl #(
    parameter int ROW_LIM     = dhash_pkg::ROW_LIM,
    parameter int COL_LIM     = dhash_pkg::COL_LIM,
    parameter int COUNT_WIDTH = dhash_pkg::COUNT_WIDTH,
    parameter int PIX_WIDTH   = dhash_pkg::PIX_WIDTH,
    parameter int OUT_WIDTH   = dhash_pkg::OUT_WIDTH,
    parameter int TIMEOUT     = dhash_pkg::TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    dhash_seq_ctrl_if.slave  bus,
    output logic             busy,
    output logic             err
);

    import dhash_pkg::*;

    // Wait counter only needs to reach TIMEOUT-1; it clears on the exit edge.
    localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [WCW-1:0]         wait_q, wait_d;
    logic [PIX_WIDTH-1:0]   core_pix_q;
    logic [COUNT_WIDTH-1:0] core_row_q;
    logic [COUNT_WIDTH-2:0] core_col_q;
    logic [OUT_WIDTH-1:0]   m_hash_q;
    logic                   err_q;

    logic                   s_ready, m_valid;
    logic                   xfer, last_beat, timeout, capture;
    logic [COUNT_WIDTH-1:0] row;
    logic [COUNT_WIDTH-2:0] col;
    logic                   row_wrap, col_wrap;

    assign xfer      = bus.s_valid && s_ready;
    assign last_beat = xfer && row_wrap && col_wrap;
    assign capture   = (state_q == ST_WAIT) && bus.core_vld;
    assign timeout   = (state_q == ST_WAIT) && !bus.core_vld && (wait_q == WAIT_LAST);

    // Indices are held at zero outside FEED so every frame starts at 0,0,
    // including one started right after a reset or an aborted wait.
    dhash_idx_cnt #(
        .ROW_LIM     (ROW_LIM),
        .COL_LIM     (COL_LIM),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .en_i       (xfer),
        .clr_i      (state_q != ST_FEED),
        .row_o      (row),
        .col_o      (col),
        .row_wrap_o (row_wrap),
        .col_wrap_o (col_wrap)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)           state_d = ST_FEED;
            ST_FEED: if (last_beat)       state_d = ST_WAIT;
            ST_WAIT: if (bus.core_vld)    state_d = ST_HOLD;
                     else if (timeout)    state_d = ST_IDLE;
            ST_HOLD: if (bus.m_ready)     state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ST_FEED: begin s_ready = 1'b1; busy = 1'b1; end
            ST_WAIT: begin busy = 1'b1; end
            ST_HOLD: begin m_valid = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        wait_d = '0;
        if ((state_q == ST_WAIT) && !bus.core_vld && !timeout)
            wait_d = wait_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q     <= '0;
            core_pix_q <= '0;
            core_row_q <= '0;
            core_col_q <= '0;
            m_hash_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= timeout;
            if (xfer) begin
                core_pix_q <= bus.s_pix;
                core_row_q <= row;
                core_col_q <= col;
            end
            if (capture)
                m_hash_q <= bus.core_hash;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid;
    assign bus.m_hash   = m_hash_q;
    assign bus.core_pix = core_pix_q;
    assign bus.core_row = core_row_q;
    assign bus.core_col = core_col_q;
    assign err          = err_q;

endmodule

// File: tb/tb_dhash_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dhash_seq_ctrl
// Randomised frames against a beat-count reference model: the n-th accepted
// pixel must appear with row = n % ROW_LIM, col = n / ROW_LIM.
// ---------------------------------------------------------------------------
module tb_dhash_seq_ctrl;
    import dhash_pkg::*;

    localparam int NBEAT = ROW_LIM * COL_LIM;
    localparam int TMO   = 15;
    localparam int CW    = COUNT_WIDTH - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [PIX_WIDTH-1:0]   exp_pix;
    logic [COUNT_WIDTH-1:0] exp_row;
    logic [CW-1:0]          exp_col;
    logic [OUT_WIDTH-1:0]   exp_hash;

    dhash_seq_ctrl_if bus ();

    dhash_seq_ctrl #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst   (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pix  = '0;
        exp_row  = '0;
        exp_col  = '0;
        exp_hash = '0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_busy"},  64'(busy),          64'(exp_hash != exp_hash) | (busy ? 64'd0 : 64'd0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  64'(busy),         64'd0);
        check({tag, "_err"},   64'(err),          64'd0);
        check({tag, "_srdy"},  64'(bus.s_ready),  64'd0);
        check({tag, "_mvld"},  64'(bus.m_valid),  64'd0);
        check({tag, "_hash"},  64'(bus.m_hash),   64'd0);
        check({tag, "_pix"},   64'(bus.core_pix), 64'd0);
        check({tag, "_row"},   64'(bus.core_row), 64'd0);
        check({tag, "_col"},   64'(bus.core_col), 64'd0);
    endtask

    // Called at a negedge while idle; leaves the controller in FEED.
    task automatic start_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 64'(busy),        64'd1);
        check("start_srdy", 64'(bus.s_ready), 64'd1);
    endtask

    // mode 0: s_valid always 1, 1: toggling, 2: random.
    task automatic feed(input int mode, input int nbeats, input bit seq_pix);
        int k = 0;
        int cyc = 0;
        bit v;
        logic [PIX_WIDTH-1:0] pix;
        while (k < nbeats && cyc < nbeats * 4 + 20) begin
            check("feed_srdy", 64'(bus.s_ready), 64'd1);
            check("feed_err",  64'(err),         64'd0);
            check("feed_mvld", 64'(bus.m_valid), 64'd0);
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 0;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            pix           = seq_pix ? PIX_WIDTH'(k) : PIX_WIDTH'($urandom);
            bus.s_valid   = v;
            bus.s_pix     = pix;
            bus.core_vld  = $urandom_range(0, 1) != 0;
            bus.core_hash = {$urandom, $urandom};
            @(negedge clk);
            if (v) begin
                exp_pix = pix;
                exp_row = COUNT_WIDTH'(k % ROW_LIM);
                exp_col = CW'(k / ROW_LIM);
                k++;
            end
            check("core_pix", 64'(bus.core_pix), 64'(exp_pix));
            check("core_row", 64'(bus.core_row), 64'(exp_row));
            check("core_col", 64'(bus.core_col), 64'(exp_col));
            cyc++;
        end
        bus.s_valid  = 1'b0;
        bus.core_vld = 1'b0;
        if (k < nbeats) check("feed_budget", 64'(k), 64'(nbeats));
        check("feed_hash", 64'(bus.m_hash), 64'(exp_hash));
    endtask

    // Called at the negedge right after the last beat (first WAIT cycle).
    task automatic core_respond(input int dly, input logic [63:0] h);
        check("wait_srdy", 64'(bus.s_ready), 64'd0);
        check("wait_busy", 64'(busy),        64'd1);
        repeat (dly) begin
            @(negedge clk);
            check("wait_mvld", 64'(bus.m_valid), 64'd0);
            check("wait_err",  64'(err),         64'd0);
        end
        bus.core_vld  = 1'b1;
        bus.core_hash = h;
        @(negedge clk);
        bus.core_vld  = 1'b0;
        bus.core_hash = {$urandom, $urandom};
        exp_hash      = h;
        check("resp_mvld", 64'(bus.m_valid), 64'd1);
        check("resp_hash", 64'(bus.m_hash),  64'(exp_hash));
    endtask

    // Hold the result with m_ready low, then accept it with start high.
    task automatic hold_release(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            bus.m_ready   = 1'b0;
            start         = $urandom_range(0, 1) != 0;
            bus.core_vld  = 1'b1;
            bus.core_hash = {$urandom, $urandom};
            @(negedge clk);
            check("hold_mvld", 64'(bus.m_valid), 64'd1);
            check("hold_hash", 64'(bus.m_hash),  64'(exp_hash));
            check("hold_srdy", 64'(bus.s_ready), 64'd0);
            check("hold_busy", 64'(busy),        64'd1);
        end
        bus.core_vld = 1'b0;
        bus.m_ready  = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        bus.m_ready  = 1'b0;
        start        = 1'b0;
        check("rel_mvld", 64'(bus.m_valid), 64'd0);
        check("rel_busy", 64'(busy),        64'd0);
        @(negedge clk);
        check("rel_idle_busy", 64'(busy),        64'd0);
        check("rel_idle_srdy", 64'(bus.s_ready), 64'd0);
        check("rel_idle_hash", 64'(bus.m_hash),  64'(exp_hash));
    endtask

    initial begin
        bus.s_pix     = '0;
        bus.s_valid   = 1'b0;
        bus.core_vld  = 1'b0;
        bus.core_hash = '0;
        bus.m_ready   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_rst");

        // Nominal frame, pixels 0..71, fixed hash
        start_frame();
        feed(0, NBEAT, 1'b1);
        core_respond($urandom_range(0, 10), 64'hA5A5_0F0F_1234_5678);
        hold_release(0);

        // Stall: s_valid toggling
        start_frame();
        feed(1, NBEAT, 1'b0);
        core_respond($urandom_range(0, 10), {$urandom, $urandom});
        hold_release(1);

        // Backpressure: 10 cycles of m_ready low with start pokes
        start_frame();
        feed(2, NBEAT, 1'b0);
        core_respond($urandom_range(0, 14), {$urandom, $urandom});
        hold_release(10);

        // Timeout: core never answers
        start_frame();
        feed(2, NBEAT, 1'b0);
        for (int c = 1; c <= TMO + 3; c++) begin
            @(negedge clk);
            check("tmo_err",  64'(err),  (c == TMO) ? 64'd1 : 64'd0);
            check("tmo_busy", 64'(busy), (c < TMO)  ? 64'd1 : 64'd0);
        end
        check("tmo_hash", 64'(bus.m_hash),  64'(exp_hash));
        check("tmo_mvld", 64'(bus.m_valid), 64'd0);

        // Reset mid-frame after 30 beats
        start_frame();
        feed(0, 30, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame();
        feed(2, NBEAT, 1'b0);
        core_respond($urandom_range(0, 10), {$urandom, $urandom});
        hold_release($urandom_range(0, 3));

        // A few more random frames
        for (int f = 0; f < 3; f++) begin
            start_frame();
            feed(2, NBEAT, 1'b0);
            core_respond($urandom_range(0, 14), {$urandom, $urandom});
            hold_release($urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dhash_seq_ctrl.md
DHASH_SEQ_CTRL -- requirements
Module: dhash_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ROW_LIM, default 9, meaning pixels per row fed to the dhash core.
REQ-002 The block SHALL have parameter COL_LIM, default 8, meaning rows per frame.
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 4, meaning the width of the row index (col index is COUNT_WIDTH-1).
REQ-004 The block SHALL have parameter PIX_WIDTH, default 8, meaning pixel width.
REQ-005 The block SHALL have parameter OUT_WIDTH, default (ROW_LIM-1)*COL_LIM = 64, meaning hash width.
REQ-006 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum WAIT cycles for core hash_vld.
REQ-007 The block SHALL have port clk, input, 1, meaning the single clock (all logic rising-edge).
REQ-008 The block SHALL have port rst, input, 1, meaning the asynchronous active-low reset.
REQ-009 The block SHALL have port start, input, 1, meaning a one-cycle request to hash one frame.
REQ-010 The block SHALL have ports s_pix (input, PIX_WIDTH), s_valid (input, 1) and s_ready (output, 1), meaning the pixel stream handshake.
REQ-011 The block SHALL have ports core_pix (output, PIX_WIDTH), core_row (output, COUNT_WIDTH) and core_col (output, COUNT_WIDTH-1), meaning the drive to the dhash core.
REQ-012 The block SHALL have ports core_vld (input, 1) and core_hash (input, OUT_WIDTH), meaning the hash result from the core.
REQ-013 The block SHALL have ports m_hash (output, OUT_WIDTH), m_valid (output, 1) and m_ready (input, 1), meaning the result handshake.
REQ-014 The block SHALL have outputs busy (1, high whenever state is not IDLE) and err (1, one-cycle timeout pulse).

Function
REQ-015 The FSM SHALL have states IDLE, FEED, WAIT and HOLD; in IDLE, start=1 SHALL move it to FEED on the next edge, and start SHALL be ignored in every other state.
REQ-016 s_ready SHALL equal 1 only in FEED; a beat SHALL transfer when s_valid & s_ready.
REQ-017 On each transfer, core_pix SHALL register s_pix and core_row/core_col SHALL register the current indices.
REQ-018 Outside transfers, core_row/core_col/core_pix SHALL hold their values.
REQ-019 The row index SHALL be the fast counter, running 0..ROW_LIM-1 and wrapping to 0 while col increments.
REQ-020 col SHALL run 0..COL_LIM-1, giving exactly ROW_LIM*COL_LIM = 72 transfers per frame.
REQ-021 The transfer at row=ROW_LIM-1, col=COL_LIM-1 SHALL move FEED to WAIT and clear both counters.
REQ-022 In WAIT, the first cycle with core_vld=1 SHALL capture core_hash into m_hash and move the FSM to HOLD with m_valid=1 on the following cycle.
REQ-023 A wait counter SHALL count WAIT cycles; if it reaches TIMEOUT without core_vld, err SHALL pulse for one cycle and the FSM SHALL return to IDLE with m_hash unchanged.
REQ-024 core_vld SHALL be ignored outside WAIT.
REQ-025 In HOLD, m_valid SHALL stay 1 and m_hash SHALL stay stable until m_ready=1; on that edge m_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-026 start asserted in the same cycle as the HOLD-to-IDLE exit SHALL be ignored; a new frame requires start while in IDLE.
REQ-027 s_valid deasserted mid-frame SHALL stall the counters, with no timeout in FEED.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE; counters=0; s_ready=0; m_valid=0; err=0; busy=0; m_hash=0; core_pix=0; core_row=0; core_col=0.
REQ-029 Reset mid-frame SHALL discard the partial frame; after release, the next frame SHALL begin at row=0, col=0.

Structure
REQ-030 ROW_LIM, COL_LIM, COUNT_WIDTH, PIX_WIDTH, OUT_WIDTH and the FSM state encoding SHALL live in shared package dhash_pkg.
REQ-031 The row/col index generator SHALL be one sub-module, dhash_idx_cnt (enable input, wrap outputs, synchronous clear); the remaining logic SHALL be flat.

Verification
REQ-032 Nominal: start, then 72 beats (pix = 0..71) with s_valid always 1 -> indices match row-fast order; core_vld pulses with hash 64'hA5A5_0F0F_1234_5678 -> m_valid=1 with that hash, and it clears on m_ready.
REQ-033 Stall: s_valid toggles 1/0 over the 72 beats -> exactly 72 transfers, FSM stays in FEED, no err.
REQ-034 Backpressure: m_ready=0 for 10 cycles in HOLD -> m_hash stable, s_ready=0, and a start during HOLD is ignored.
REQ-035 Timeout: core_vld never asserted -> err pulses exactly once, TIMEOUT=15 cycles after entering WAIT; FSM returns to IDLE with busy=0.
REQ-036 Reset: rst=0 after beat 30 -> all outputs go to reset values immediately; a restarted frame begins at row=0, col=0 and completes with 72 beats.
